// File: rtl/falafel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : falafel_pkg
// Description : Shared types and sizing constants for the falafel allocator
//               datapath (allocation request entry, word type, FIFO depth).
// Revision    : 1.0 - initial release
// ============================================================================
package falafel_pkg;

  localparam int DATA_W           = 32;
  localparam int MSG_ID_SIZE      = 4;
  // Depth of the arbiter -> allocator request FIFO, shared with the arbiter.
  localparam int ALLOC_FIFO_DEPTH = 8;

  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    word_t                  size;
    logic [MSG_ID_SIZE-1:0] id;
  } alloc_entry_t;

endpackage : falafel_pkg
`default_nettype wire

// File: rtl/falafel_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : falafel_fifo_ctrl
// Description : Pointer/occupancy controller for a power-of-two FIFO. Holds
//               read/write pointers and the count register and decodes the
//               full, empty and almost-full flags from the registered count.
// Revision    : 1.0 - initial release
// ============================================================================
module falafel_fifo_ctrl #(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       write_i,
  input  logic                       read_i,
  output logic                       push_o,
  output logic [$clog2(DEPTH)-1:0]   wptr_o,
  output logic [$clog2(DEPTH)-1:0]   rptr_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;

  // Flags come only from the count register, never from the request inputs.
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign almost_full_o = (count_q >= CNT_W'(AFULL_THRESH));

  // A flush swallows any push or pop presented in the same cycle.
  assign push_o = write_i & ~full_o & ~clear_i;
  assign pop    = read_i & ~empty_o & ~clear_i;

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;

  // Next-state for pointers and count; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_o) wptr_d = wptr_q + PTR_W'(1);
      if (pop)    rptr_d = rptr_q + PTR_W'(1);
      if (push_o && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push_o) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule : falafel_fifo_ctrl
`default_nettype wire

// File: rtl/falafel_alloc_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : falafel_alloc_req_fifo
// Description : First-word-fall-through FIFO carrying allocation requests
//               from the input arbiter to the allocator core, with occupancy,
//               almost-full and sticky overflow visibility.
// Revision    : 1.0 - initial release
// ============================================================================
module falafel_alloc_req_fifo
  import falafel_pkg::*;
#(
  parameter int DEPTH        = ALLOC_FIFO_DEPTH,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    fifo_write_i,
  input  word_t                   fifo_din_size_i,
  input  logic [MSG_ID_SIZE-1:0]  fifo_din_id_i,
  output logic                    fifo_full_o,
  output logic                    almost_full_o,
  output logic                    req_val_o,
  input  logic                    req_rdy_i,
  output word_t                   req_size_o,
  output logic [MSG_ID_SIZE-1:0]  req_id_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);

  alloc_entry_t     mem_q [DEPTH];
  alloc_entry_t     head;
  logic             push;
  logic             empty;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             overflow_q, overflow_d;

  falafel_fifo_ctrl #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_ctrl (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .write_i       (fifo_write_i),
    .read_i        (req_rdy_i),
    .push_o        (push),
    .wptr_o        (wptr),
    .rptr_o        (rptr),
    .count_o       (count_o),
    .full_o        (fifo_full_o),
    .empty_o       (empty),
    .almost_full_o (almost_full_o)
  );

  // Storage array; contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr] <= '{size: fifo_din_size_i, id: fifo_din_id_i};
    end
  end

  // Sticky overflow: a write that meets a full FIFO is dropped and recorded.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_i)                         overflow_d = 1'b0;
    else if (fifo_write_i && fifo_full_o) overflow_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  // Head entry falls through from registered state; zeroed when not valid so
  // stale storage never leaks onto the stream.
  assign head       = mem_q[rptr];
  assign req_val_o  = ~empty;
  assign req_size_o = req_val_o ? head.size : '0;
  assign req_id_o   = req_val_o ? head.id   : '0;
  assign overflow_o = overflow_q;

endmodule : falafel_alloc_req_fifo
`default_nettype wire

// File: tb/tb_falafel_alloc_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_falafel_alloc_req_fifo
// Description : Self-checking bench for falafel_alloc_req_fifo: queue-based
//               reference model compared every cycle, directed scenarios
//               with literal expectations, randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_falafel_alloc_req_fifo;
  import falafel_pkg::*;

  localparam int DEPTH = 8;
  localparam int AFULL = 6;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        fifo_write_i = 1'b0;
  word_t       fifo_din_size_i = '0;
  logic [MSG_ID_SIZE-1:0] fifo_din_id_i = '0;
  logic        fifo_full_o;
  logic        almost_full_o;
  logic        req_val_o;
  logic        req_rdy_i = 1'b0;
  word_t       req_size_o;
  logic [MSG_ID_SIZE-1:0] req_id_o;
  logic [3:0]  count_o;
  logic        overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  falafel_alloc_req_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .fifo_write_i    (fifo_write_i),
    .fifo_din_size_i (fifo_din_size_i),
    .fifo_din_id_i   (fifo_din_id_i),
    .fifo_full_o     (fifo_full_o),
    .almost_full_o   (almost_full_o),
    .req_val_o       (req_val_o),
    .req_rdy_i       (req_rdy_i),
    .req_size_o      (req_size_o),
    .req_id_o        (req_id_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of accepted requests plus an overflow bit.
  alloc_entry_t model_q[$];
  bit           model_ovf;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else if (clear_i) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      bit was_full;
      bit do_pop;
      was_full = (model_q.size() == DEPTH);
      do_pop   = (model_q.size() != 0) && req_rdy_i;
      if (fifo_write_i && was_full) model_ovf = 1'b1;
      if (do_pop) void'(model_q.pop_front());
      if (fifo_write_i && !was_full)
        model_q.push_back('{size: fifo_din_size_i, id: fifo_din_id_i});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    int n;
    n = model_q.size();
    check("cmp_val",   req_val_o,     n != 0);
    check("cmp_size",  req_size_o,    (n != 0) ? model_q[0].size : 0);
    check("cmp_id",    req_id_o,      (n != 0) ? model_q[0].id   : 0);
    check("cmp_count", count_o,       n);
    check("cmp_full",  fifo_full_o,   n == DEPTH);
    check("cmp_afull", almost_full_o, n >= AFULL);
    check("cmp_ovf",   overflow_o,    model_ovf);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_wr(input bit wr, input int size, input int id);
    fifo_write_i    = wr;
    fifo_din_size_i = word_t'(size);
    fifo_din_id_i   = id[MSG_ID_SIZE-1:0];
  endtask

  initial begin
    // Reset and idle.
    repeat (3) tick();
    check("rst_val",   req_val_o,   0);
    check("rst_count", count_o,     0);
    check("rst_full",  fifo_full_o, 0);
    check("rst_ovf",   overflow_o,  0);
    check("rst_size",  req_size_o,  0);
    rst_i = 1'b0;
    repeat (2) tick();

    // Single push, held stable, then popped.
    set_wr(1, 'h40, 3);
    tick();
    set_wr(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("hold_val",  req_val_o,  1);
      check("hold_size", req_size_o, 'h40);
      check("hold_id",   req_id_o,   3);
      tick();
    end
    req_rdy_i = 1'b1;
    tick();
    req_rdy_i = 1'b0;
    check("pop1_val",   req_val_o, 0);
    check("pop1_count", count_o,   0);

    // Fill to full, watching the flags.
    for (int i = 1; i <= 8; i++) begin
      set_wr(1, i, i);
      tick();
      check("fill_count", count_o,       i);
      check("fill_afull", almost_full_o, i >= 6);
      check("fill_full",  fifo_full_o,   i == 8);
    end
    set_wr(1, 9, 9);
    tick();
    check("ovf_set",   overflow_o, 1);
    check("ovf_count", count_o,    8);

    // Full with simultaneous write and pop: write dropped, pop taken.
    set_wr(1, 99, 1);
    req_rdy_i = 1'b1;
    tick();
    set_wr(0, 0, 0);
    req_rdy_i = 1'b0;
    check("fpop_count", count_o,    7);
    check("fpop_ovf",   overflow_o, 1);
    check("fpop_head",  req_size_o, 2);

    // Drain the rest in order.
    req_rdy_i = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      check("drain_size", req_size_o, i);
      tick();
    end
    req_rdy_i = 1'b0;
    check("drain_empty", req_val_o,  0);
    check("drain_ovf",   overflow_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_ovf", overflow_o, 0);

    // Steady state at count 4 with push and pop every cycle across wrap.
    for (int i = 0; i < 4; i++) begin
      set_wr(1, 100 + i, i);
      tick();
    end
    req_rdy_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_wr(1, 200 + k, k);
      check("ss_count", count_o, 4);
      check("ss_head",  req_size_o, (k < 4) ? 100 + k : 200 + k - 4);
      tick();
    end
    set_wr(0, 0, 0);
    req_rdy_i = 1'b0;
    check("ss_end_count", count_o, 4);

    // Clear at count 5 with overflow set and a concurrent push.
    for (int i = 0; i < 5; i++) begin
      set_wr(1, 300 + i, i);
      tick();
    end
    check("pre_full", fifo_full_o, 1);
    tick();                                   // write while full -> overflow
    set_wr(0, 0, 0);
    req_rdy_i = 1'b1;
    repeat (3) tick();
    req_rdy_i = 1'b0;
    check("pre_clr_count", count_o,    5);
    check("pre_clr_ovf",   overflow_o, 1);
    set_wr(1, 'h77, 7);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    set_wr(0, 0, 0);
    check("clr_count", count_o,    0);
    check("clr_val",   req_val_o,  0);
    check("clr_ovf2",  overflow_o, 0);
    repeat (3) tick();
    check("clr_gone", req_val_o, 0);

    // Randomized traffic in phases biased towards fill, drain and balance.
    for (int ph = 0; ph < 4; ph++) begin
      int wpct;
      int rpct;
      wpct = (ph == 0) ? 85 : (ph == 1) ? 20 : (ph == 2) ? 50 : 95;
      rpct = (ph == 0) ? 30 : (ph == 1) ? 85 : (ph == 2) ? 50 : 15;
      for (int c = 0; c < 500; c++) begin
        set_wr($urandom_range(99) < wpct, int'($urandom), int'($urandom));
        req_rdy_i = ($urandom_range(99) < rpct);
        clear_i   = ($urandom_range(249) == 0);
        tick();
      end
      if (ph == 1) begin
        // Asynchronous reset mid-traffic with entries buffered.
        set_wr(1, 5, 5);
        req_rdy_i = 1'b0;
        clear_i   = 1'b0;
        repeat (3) tick();
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_val",   req_val_o,     0);
        check("arst_count", count_o,       0);
        check("arst_full",  fifo_full_o,   0);
        check("arst_afull", almost_full_o, 0);
        check("arst_ovf",   overflow_o,    0);
        check("arst_size",  req_size_o,    0);
        tick();
        rst_i = 1'b0;
      end
    end
    set_wr(0, 0, 0);
    req_rdy_i = 1'b0;
    clear_i   = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_falafel_alloc_req_fifo
`default_nettype wire

// File: doc/falafel_alloc_req_fifo.md
Name: falafel_alloc_req_fifo

Overview:
Buffers allocation requests (size, message ID) between the input arbitration stage and the allocator core. The write side is the arbiter's alloc FIFO interface: full, write, size, and id. The read side is a first-word-fall-through valid/ready stream into the allocator FSM. The block also exposes occupancy, an almost-full flag, and a sticky overflow flag for debug and config visibility.

Parameters:
DEPTH, 8, number of entries; power of two, at least 2.
AFULL_THRESH, DEPTH-2, almost_full_o asserts when count_o is at least this value; range 1..DEPTH.
CNT_W, $clog2(DEPTH)+1, localparam; width of the occupancy count.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
clear_i  in  1  synchronous flush of all entries and of the overflow flag.
fifo_write_i  in  1  push request from the arbiter.
fifo_din_size_i  in  DATA_W (word_t)  requested allocation size.
fifo_din_id_i  in  MSG_ID_SIZE  request message ID.
fifo_full_o  out  1  high when count_o == DEPTH.
almost_full_o  out  1  high when count_o >= AFULL_THRESH.
req_val_o  out  1  head entry valid.
req_rdy_i  in  1  consumer accepts the head entry.
req_size_o  out  DATA_W  size field of the head entry.
req_id_o  out  MSG_ID_SIZE  id field of the head entry.
count_o  out  CNT_W  current occupancy, 0..DEPTH.
overflow_o  out  1  sticky; set when a write arrives while the FIFO is full.

Behaviour:
- Storage: DEPTH x alloc_entry_t register array. Read and write pointers are $clog2(DEPTH) bits, plus a count register.
- Reset (rst_i high, async): pointers = 0, count = 0, overflow = 0. Outputs: req_val_o=0, fifo_full_o=0, almost_full_o=0 (AFULL_THRESH >= 1), count_o=0, overflow_o=0. Storage contents are don't-care, but req_size_o/req_id_o must be driven to 0 whenever req_val_o=0.
- push = fifo_write_i & ~full. pop = req_val_o & req_rdy_i.
- Write: on push, entry {size, id} goes into mem[wptr], and wptr increments, wrapping modulo DEPTH.
- Read (FWFT): req_val_o = (count != 0). req_size_o/req_id_o = mem[rptr], combinational from registered state. On pop, rptr increments with wrap.
- Latency: a push in cycle N makes the entry visible on req_val_o in cycle N+1. There is no same-cycle bypass when empty.
- Count: push only -> +1; pop only -> -1; push and pop together -> unchanged.
- Full with a simultaneous pop: the write is still refused, because full is evaluated on registered count. The pop proceeds and count becomes DEPTH-1.
- Write while full: the entry is dropped, and overflow sets at the next edge and holds until clear_i or reset. Pointers and count are unchanged.
- Empty with req_rdy_i high: no pop and no state change.
- Ready independence: req_val_o must not depend on req_rdy_i. req_rdy_i may be high at any time.
- Flags: fifo_full_o, almost_full_o and count_o are decoded from the count register. There is no combinational path from fifo_write_i or req_rdy_i to any output.
- clear_i: at the next edge, pointers, count and overflow go to 0. It has priority over a simultaneous push or pop, and that push or pop is discarded.
- Reset mid-operation: every entry is lost, and outputs reach their reset values asynchronously.
- Stability: the head entry must stay stable while req_val_o=1 and req_rdy_i=0.

Decomposition:
- falafel_pkg already provides alloc_entry_t (size: word_t, id: MSG_ID_SIZE bits), DATA_W and MSG_ID_SIZE.
- Add ALLOC_FIFO_DEPTH (default 8) to falafel_pkg so the arbiter and the top level share it.
- One sub-module is natural: falafel_fifo_ctrl. It holds the pointers, count, full/empty and almost-full logic, parameterised by DEPTH and AFULL_THRESH, and is reusable for the free-request FIFO.
- The storage array and the overflow flag stay in falafel_alloc_req_fifo.

Test Plan:
- Reset then idle: req_val_o=0, count_o=0, fifo_full_o=0, overflow_o=0, req_size_o=0. Assert rst_i mid-traffic -> the same values appear immediately.
- Push (size=0x40, id=3) with req_rdy_i=0 -> req_val_o=1 the next cycle with size 0x40, id 3, held stable for 5 cycles. Raise req_rdy_i -> req_val_o=0 the following cycle, count_o=0.
- 8 pushes (sizes 1..8, DEPTH=8), no pops -> almost_full_o rises when count_o=6, fifo_full_o=1 at count 8. A 9th write (size 9) -> overflow_o=1, count stays 8. Draining yields sizes 1..8 in order.
- With DEPTH=8, start at count 4 and drive push and pop together for 20 cycles -> count_o stays at 4, and the output order matches input order across pointer wrap-around.
- Full FIFO with fifo_write_i=1 and req_rdy_i=1 in the same cycle -> the pop is accepted, the write is dropped, count_o=7, overflow_o=1.
- clear_i asserted at count 5 with overflow set and a push in the same cycle -> the next cycle shows count_o=0, req_val_o=0, overflow_o=0, and the pushed entry never appears.
